mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit that issues one Avalon-MM read or write per request.
// It handles byte-lane steering, load sign/zero extension, misalignment errors and wait timeouts.
module mem_access_unit #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misalign_err,
   output logic        timeout_err,
   output logic [31:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic        write_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  off_q;
   logic [31:0] wait_cnt;

   logic        aligned;
   logic        timeout_hit;
   logic [3:0]  be_nxt;
   logic [31:0] wd_nxt;
   logic [31:0] lane;
   logic [31:0] load_ext;

   always_comb begin
      aligned = 1'b0;
      be_nxt  = '0;
      wd_nxt  = '0;
      case (req_size)
         2'b00: begin
            aligned = 1'b1;
            be_nxt  = 4'b0001 << req_addr[1:0];
            wd_nxt  = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~req_addr[0];
            be_nxt  = 4'b0011 << req_addr[1:0];
            wd_nxt  = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            aligned = (req_addr[1:0] == 2'b00);
            be_nxt  = 4'b1111;
            wd_nxt  = req_wdata;
         end
         default: aligned = 1'b0;
      endcase
   end

   // Abort on the edge that would complete the WAIT_LIMIT-th stalled cycle.
   assign timeout_hit = (WAIT_LIMIT != 0) && avm_waitrequest &&
                        (wait_cnt == WAIT_LIMIT - 32'd1);

   assign lane = avm_readdata >> {off_q, 3'b000};

   always_comb begin
      case (size_q)
         2'b00:   load_ext = signed_q ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
         2'b01:   load_ext = signed_q ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = aligned ? ISSUE : DONE;
         ISSUE: begin
            if (!avm_waitrequest) state_nxt = write_q ? DONE : RDWAIT;
            else if (timeout_hit) state_nxt = DONE;
         end
         RDWAIT:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE);
   assign avm_read   = (state == ISSUE) && !write_q;
   assign avm_write  = (state == ISSUE) && write_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         write_q        <= 1'b0;
         size_q         <= '0;
         signed_q       <= 1'b0;
         off_q          <= '0;
         wait_cnt       <= '0;
         avm_address    <= '0;
         avm_byteenable <= '0;
         avm_writedata  <= '0;
         resp_rdata     <= '0;
         misalign_err   <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  write_q  <= req_write;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  off_q    <= req_addr[1:0];
                  wait_cnt <= '0;
                  if (aligned) begin
                     avm_address    <= {req_addr[31:2], 2'b00};
                     avm_byteenable <= be_nxt;
                     avm_writedata  <= wd_nxt;
                  end else begin
                     resp_rdata   <= '0;
                     misalign_err <= 1'b1;
                     timeout_err  <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               if (!avm_waitrequest) begin
                  if (write_q) begin
                     resp_rdata   <= '0;
                     misalign_err <= 1'b0;
                     timeout_err  <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  resp_rdata   <= '0;
                  misalign_err <= 1'b0;
                  timeout_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            RDWAIT: begin
               resp_rdata   <= load_ext;
               misalign_err <= 1'b0;
               timeout_err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a cycle-level Avalon slave inside an access task,
// with hand-computed expectations for lanes, extension, latency, errors and reset abort.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        busy, resp_valid, misalign_err, timeout_err;
   logic [31:0] resp_rdata, avm_address, avm_writedata, avm_readdata;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write, avm_waitrequest;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   int          r_lat, r_strobes;
   logic        r_unstable, r_done, r_is_write;
   logic [3:0]  r_be;
   logic [31:0] r_wd, r_addr, r_rdata;
   logic        r_merr, r_terr;

   always #5 clk = ~clk;

   mem_access_unit #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .misalign_err(misalign_err), .timeout_err(timeout_err),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One request; the slave stalls the first nwait strobe cycles and returns rd one cycle after read acceptance.
   task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int nwait, input logic [31:0] rd);
      int   waits;
      logic rd_next;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      avm_waitrequest = 1'b0; avm_readdata = 32'h5A5A5A5A;
      r_strobes = 0; r_unstable = 1'b0; r_done = 1'b0; r_is_write = 1'b0;
      r_be = '0; r_wd = '0; r_addr = '0;
      waits = 0; rd_next = 1'b0;
      @(posedge clk);
      r_lat = 1;
      @(negedge clk);
      req_valid = 1'b0; req_write = ~w; req_size = 2'b11; req_signed = ~sg;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1357_9BDF;
      while (!r_done && r_lat < 40) begin
         avm_readdata = rd_next ? rd : 32'h5A5A5A5A;
         rd_next = 1'b0;
         if (resp_valid) begin
            r_done = 1'b1;
            r_rdata = resp_rdata; r_merr = misalign_err; r_terr = timeout_err;
         end else begin
            if (avm_read && avm_write) r_unstable = 1'b1;
            if (avm_read || avm_write) begin
               if (r_strobes == 0) begin
                  r_is_write = avm_write; r_be = avm_byteenable;
                  r_wd = avm_writedata; r_addr = avm_address;
               end else if (r_is_write != avm_write || r_be != avm_byteenable ||
                            r_wd != avm_writedata || r_addr != avm_address) begin
                  r_unstable = 1'b1;
               end
               r_strobes++;
               if (waits < nwait) begin
                  avm_waitrequest = 1'b1;
                  waits++;
               end else begin
                  avm_waitrequest = 1'b0;
                  rd_next = avm_read;
               end
            end else begin
               avm_waitrequest = 1'b0;
            end
            @(posedge clk);
            r_lat++;
            @(negedge clk);
         end
      end
      avm_waitrequest = 1'b0;
      if (!r_done) check("resp_wait_bound", 32'd0, 32'd1);
   endtask

   logic seen;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; avm_waitrequest = 1'b0; avm_readdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_strobes", {30'b0, avm_read, avm_write}, 32'd0);
      check("rst_resp", {29'b0, resp_valid, misalign_err, timeout_err}, 32'd0);
      check("rst_addr", avm_address, 32'd0);
      check("rst_be", {28'b0, avm_byteenable}, 32'd0);
      check("rst_wdata", avm_writedata, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      reset = 1'b0;

      // Store word, no stall
      access(1'b1, 2'b10, 1'b0, 32'hBFC00010, 32'hDEADBEEF, 0, 32'h0);
      check("sw_lat", r_lat, 32'd2);
      check("sw_strobes", r_strobes, 32'd1);
      check("sw_is_write", {31'b0, r_is_write}, 32'd1);
      check("sw_be", {28'b0, r_be}, 32'h0000000F);
      check("sw_addr", r_addr, 32'hBFC00010);
      check("sw_wdata", r_wd, 32'hDEADBEEF);
      check("sw_errs", {30'b0, r_merr, r_terr}, 32'd0);
      check("sw_rdata", r_rdata, 32'd0);

      // Load byte signed / unsigned from the top lane
      access(1'b0, 2'b00, 1'b1, 32'hBFC00013, 32'h0, 0, 32'h80FF0011);
      check("lbs_lat", r_lat, 32'd3);
      check("lbs_be", {28'b0, r_be}, 32'h00000008);
      check("lbs_addr", r_addr, 32'hBFC00010);
      check("lbs_is_write", {31'b0, r_is_write}, 32'd0);
      check("lbs_rdata", r_rdata, 32'hFFFFFF80);
      repeat (3) @(negedge clk);
      check("rdata_hold", resp_rdata, 32'hFFFFFF80);
      check("idle_busy", {31'b0, busy}, 32'd0);
      access(1'b0, 2'b00, 1'b0, 32'hBFC00013, 32'h0, 0, 32'h80FF0011);
      check("lbu_rdata", r_rdata, 32'h00000080);

      // Load half unsigned with three stall cycles
      access(1'b0, 2'b01, 1'b0, 32'h00000102, 32'h0, 3, 32'h1234ABCD);
      check("lh_strobes", r_strobes, 32'd4);
      check("lh_stable", {31'b0, r_unstable}, 32'd0);
      check("lh_be", {28'b0, r_be}, 32'h0000000C);
      check("lh_lat", r_lat, 32'd6);
      check("lh_rdata", r_rdata, 32'h00001234);
      access(1'b0, 2'b01, 1'b1, 32'h00000100, 32'h0, 0, 32'h1234ABCD);
      check("lhs_low_rdata", r_rdata, 32'hFFFFABCD);

      // Misaligned half store: no bus activity, error response
      access(1'b1, 2'b01, 1'b0, 32'h00000201, 32'h0000BEEF, 0, 32'h0);
      check("mis_strobes", r_strobes, 32'd0);
      check("mis_lat", r_lat, 32'd1);
      check("mis_err", {30'b0, r_merr, r_terr}, 32'd2);
      check("mis_rdata", r_rdata, 32'd0);
      access(1'b0, 2'b11, 1'b0, 32'h00000200, 32'h0, 0, 32'h0);
      check("rsvd_size", {30'b0, r_merr, r_strobes == 0}, 32'd3);

      // Store byte at lane 2
      access(1'b1, 2'b00, 1'b0, 32'h00000302, 32'h000000AB, 0, 32'h0);
      check("sb_be", {28'b0, r_be}, 32'h00000004);
      check("sb_wdata", r_wd, 32'hABABABAB);
      check("sb_errs", {30'b0, r_merr, r_terr}, 32'd0);
      access(1'b1, 2'b01, 1'b0, 32'h00000306, 32'h00005678, 1, 32'h0);
      check("sh_be_wd", {r_be, r_wd[27:0]}, {4'hC, 28'h6785678});
      check("sh_lat", r_lat, 32'd3);

      // Timeout with WAIT_LIMIT=4
      access(1'b0, 2'b10, 1'b0, 32'h00000400, 32'h0, 100, 32'h0);
      check("to_strobes", r_strobes, 32'd4);
      check("to_lat", r_lat, 32'd5);
      check("to_errs", {30'b0, r_merr, r_terr}, 32'd1);
      check("to_rdata", r_rdata, 32'd0);

      // Reset during RDWAIT aborts the access
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h00000500;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("ra_read_issued", {31'b0, avm_read}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("ra_busy_pre", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      avm_readdata = 32'h11111111;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("ra_busy", {31'b0, busy}, 32'd0);
      check("ra_strobes", {30'b0, avm_read, avm_write}, 32'd0);
      seen = resp_valid;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | resp_valid;
      end
      check("ra_no_resp", {31'b0, seen}, 32'd0);
      access(1'b0, 2'b10, 1'b0, 32'h00000504, 32'h0, 0, 32'hCAFEF00D);
      check("ra_after_lat", r_lat, 32'd3);
      check("ra_after_rdata", r_rdata, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "simulation time limit");
   end

endmodule
